// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I core: accepts a read or write request, stalls the core
// for WAIT_CYCLES+1 cycles, then commits the byte-masked write or returns the registered read word.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wr,
    input  logic [3:0]  i_data_rd_en_ctrl,
    input  logic        i_data_rd_en,
    input  logic        i_data_wr_en,
    output logic [31:0] o_data_rd,
    output logic        o_data_ready,
    output logic        o_data_err
);
    // state | meaning
    // IDLE  | waiting for a request; ready follows !req combinationally
    // BUSY  | wait states counting down; request inputs ignored
    // DONE  | response valid for one cycle; ready high
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              req, capture, enter_done, bad;
    logic [31:0]       addr_q, wdata_q;
    logic [3:0]        mask_q;
    logic              rd_q, wr_q;
    logic [31:0]       cur_addr, cur_wdata, off;
    logic [3:0]        cur_mask;
    logic              cur_rd, cur_wr;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       mem [DEPTH_WORDS];

    assign req = i_data_rd_en | i_data_wr_en;

    // In IDLE the live inputs are used so a zero-wait access can complete on its accepting edge.
    always_comb begin
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_mask  = mask_q;
        cur_rd    = rd_q;
        cur_wr    = wr_q;
        if (state == IDLE) begin
            cur_addr  = i_data_addr;
            cur_wdata = i_data_wr;
            cur_mask  = i_data_rd_en_ctrl;
            cur_rd    = i_data_rd_en;
            cur_wr    = i_data_wr_en;
        end
    end

    assign off = cur_addr - BASE_ADDR;
    assign idx = off[IDX_W+1:2];
    assign bad = (off[1:0] != 2'b00) || ((off >> (IDX_W + 2)) != 32'd0) || (cur_rd && cur_wr);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        o_data_ready = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                o_data_ready = !req;
                if (req) begin
                    capture   = 1'b1;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES > 0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = DONE;
            end
            DONE: begin
                o_data_ready = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) o_data_ready = 1'b0;
    end

    assign enter_done = (state != DONE) && (state_nxt == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            o_data_rd  <= 32'd0;
            o_data_err <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            mask_q     <= 4'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                addr_q  <= i_data_addr;
                wdata_q <= i_data_wr;
                mask_q  <= i_data_rd_en_ctrl;
                rd_q    <= i_data_rd_en;
                wr_q    <= i_data_wr_en;
            end
            if (enter_done) begin
                o_data_err <= bad;
                if (bad)
                    o_data_rd <= 32'd0;
                else if (cur_rd)
                    o_data_rd <= mem[idx];
            end
        end
    end

    // Array has no reset; a reset coinciding with DONE entry suppresses the commit.
    always_ff @(posedge clk) begin
        if (rst_n && enter_done && cur_wr && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_mask[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one DUT with two wait states, one with zero wait states.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic [3:0]  mask = '0;
    logic        rd_en = 1'b0, wr_en = 1'b0, ready, err;
    logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
    logic [3:0]  mask0 = '0;
    logic        rd_en0 = 1'b0, wr_en0 = 1'b0, ready0, err0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .i_data_addr(addr), .i_data_wr(wdata),
        .i_data_rd_en_ctrl(mask), .i_data_rd_en(rd_en), .i_data_wr_en(wr_en),
        .o_data_rd(rdata), .o_data_ready(ready), .o_data_err(err));

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_data_addr(addr0), .i_data_wr(wdata0),
        .i_data_rd_en_ctrl(mask0), .i_data_rd_en(rd_en0), .i_data_wr_en(wr_en0),
        .o_data_rd(rdata0), .o_data_ready(ready0), .o_data_err(err0));

    task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        if (sel == 0) begin
            addr = a; wdata = d; mask = m; rd_en = rd; wr_en = wr;
        end else begin
            addr0 = a; wdata0 = d; mask0 = m; rd_en0 = rd; wr_en0 = wr;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready : ready0;
    endfunction

    // Drives a request at a falling edge, counts stalled cycles, returns the DONE-cycle outputs.
    task automatic access(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          output logic [31:0] rv, output logic ev, output int low);
        bit done = 0;
        @(negedge clk);
        drive(sel, rd, wr, a, d, m);
        low = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (get_ready(sel)) begin
                done = 1;
                break;
            end
            low++;
            @(negedge clk);
        end
        rv = (sel == 0) ? rdata : rdata0;
        ev = (sel == 0) ? err : err0;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_timeout addr=%h: ready never rose within 40 cycles", a);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready); end
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b want 0", ready0); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", ready); end
    endtask

    task automatic test_basic();
        logic [31:0] rv; logic ev; int low;
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rv, ev, low);
        checks++; if (low != 3) begin errors++; $display("FAIL wr_stall got %0d want 3", low); end
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", ev); end
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rv, ev, low);
        checks++; if (low != 3) begin errors++; $display("FAIL rd_stall got %0d want 3", low); end
        checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rv); end
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", ev); end
        @(negedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL after_done_ready got %b want 1", ready); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rv; logic ev; int low;
        access(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rv, ev, low);
        access(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rv, ev, low);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rv, ev, low);
        checks++; if (rv !== 32'h11BB33DD) begin errors++; $display("FAIL mask_data got %h want 11bb33dd", rv); end
        access(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rv, ev, low);
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL mask0_err got %b want 0", ev); end
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rv, ev, low);
        checks++; if (rv !== 32'h11BB33DD) begin errors++; $display("FAIL mask0_data got %h want 11bb33dd", rv); end
    endtask

    task automatic test_errors();
        logic [31:0] rv; logic ev; int low;
        access(0, 1'b0, 1'b1, 32'h0, 32'hA5A55A5A, 4'hF, rv, ev, low);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, rv, ev, low);
        access(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'h0, rv, ev, low);
        checks++; if (ev !== 1'b1 || rv !== 32'h0) begin errors++; $display("FAIL misalign got err=%b data=%h want 1/0", ev, rv); end
        access(0, 1'b1, 1'b0, 32'h1002, 32'h0, 4'h0, rv, ev, low);
        checks++; if (ev !== 1'b1 || rv !== 32'h0) begin errors++; $display("FAIL misalign_oor got err=%b data=%h want 1/0", ev, rv); end
        access(0, 1'b0, 1'b1, 32'h1000, 32'h55, 4'hF, rv, ev, low);
        checks++; if (ev !== 1'b1 || rv !== 32'h0) begin errors++; $display("FAIL oor_wr got err=%b data=%h want 1/0", ev, rv); end
        checks++; if (low != 3) begin errors++; $display("FAIL oor_stall got %0d want 3", low); end
        access(0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, rv, ev, low);
        checks++; if (ev !== 1'b1 || rv !== 32'h0) begin errors++; $display("FAIL both_en got err=%b data=%h want 1/0", ev, rv); end
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rv, ev, low);
        checks++; if (ev !== 1'b0 || rv !== 32'hA5A55A5A) begin errors++; $display("FAIL word0 got err=%b data=%h want 0/a5a55a5a", ev, rv); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rv; logic ev; int low;
        logic exp_rdy;
        access(1, 1'b0, 1'b1, 32'h0, 32'h00001111, 4'hF, rv, ev, low);
        checks++; if (low != 1) begin errors++; $display("FAIL w0_stall got %0d want 1", low); end
        access(1, 1'b0, 1'b1, 32'h4, 32'h22220000, 4'hF, rv, ev, low);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = ((c % 2) == 1);
            checks++;
            if (ready0 !== exp_rdy) begin errors++; $display("FAIL b2b_ready cyc=%0d got %b want %b", c, ready0, exp_rdy); end
            if (c == 1) begin
                checks++; if (rdata0 !== 32'h00001111) begin errors++; $display("FAIL b2b_rd0 got %h want 00001111", rdata0); end
                drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
            end else if (c == 3) begin
                checks++; if (rdata0 !== 32'h22220000) begin errors++; $display("FAIL b2b_rd4 got %h want 22220000", rdata0); end
                drive(1, 1'b0, 1'b1, 32'h8, 32'h33334444, 4'hF);
            end else if (c == 5) begin
                checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL b2b_wr_err got %b want 0", err0); end
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            @(negedge clk);
        end
        access(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rv, ev, low);
        checks++; if (rv !== 32'h33334444) begin errors++; $display("FAIL b2b_wr_data got %h want 33334444", rv); end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] rv; logic ev; int low;
        access(0, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, rv, ev, low);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstbusy_ready got %b want 0", ready); end
        @(negedge clk); #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstheld_ready got %b want 0", ready); end
        checks++; if (rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL rstbusy_out got data=%h err=%b want 0/0", rdata, err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstrel_ready got %b want 1", ready); end
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, rv, ev, low);
        checks++; if (rv !== 32'h12345678) begin errors++; $display("FAIL rstbusy_mem got %h want 12345678", rv); end
        checks++; if (low != 3) begin errors++; $display("FAIL rstbusy_stall got %0d want 3", low); end
    endtask

    task automatic test_dropped_request();
        logic [31:0] rv; logic ev; int low;
        bit done = 0;
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h40, 32'h0BADF00D, 4'hF);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL drop_accept_ready got %b want 0", ready); end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h44, 32'hFFFFFFFF, 4'h0);
        low = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (ready) begin
                done = 1;
                break;
            end
            low++;
            @(negedge clk);
        end
        checks++; if (!done || low != 2) begin errors++; $display("FAIL drop_busy got %0d done=%0d want 2/1", low, done); end
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, rv, ev, low);
        checks++; if (rv !== 32'h0BADF00D) begin errors++; $display("FAIL drop_data got %h want 0badf00d", rv); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_mask();
        test_errors();
        test_back_to_back();
        test_reset_mid_busy();
        test_dropped_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder for the RV32I core's data memory interface, sitting at the memory side opposite the core's memory-access stage. It accepts the core's read/write requests, inserts a configurable number of wait states, and drives ready low for the duration so the core's hazard control stalls the pipeline. It commits byte-masked writes and returns registered read data. It also serves as the synthesizable memory model for core-level simulation.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
WAIT_CYCLES, 2, extra BUSY cycles per access (0..15)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active low
i_data_addr  input  32  byte address from core
i_data_wr  input  32  write data from core
i_data_rd_en_ctrl  input  4  byte-lane mask; bit n enables byte n (bits [8n+7:8n]) for writes
i_data_rd_en  input  1  read request
i_data_wr_en  input  1  write request
o_data_rd  output  32  read data, valid while o_data_ready=1 in DONE
o_data_ready  output  1  1 = no stall / response valid; 0 = core must stall
o_data_err  output  1  error flag for current response, valid in DONE

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). All state updates on the rising clk edge.
- FSM states: IDLE, BUSY, DONE. Cycle counter is 4 bits.
- Request: req = i_data_rd_en | i_data_wr_en.
- IDLE:
  - o_data_ready = !req. This is combinational, so a request stalls the core in the same cycle it appears.
  - If req: capture addr, wdata, mask, rd/wr flags; load counter = WAIT_CYCLES.
  - Next state is BUSY if WAIT_CYCLES>0, else DONE.
- BUSY:
  - o_data_ready=0; counter decrements each cycle.
  - Move to DONE in the cycle after the counter reads 1.
  - Request inputs are ignored; the captured transaction always completes, even if the core drops its enables.
- DONE entry edge:
  - Write: commit masked bytes to mem[idx].
  - Read: register mem[idx] into o_data_rd.
  - Set o_data_err.
- DONE:
  - o_data_ready=1 for exactly one cycle.
  - Next state is IDLE unconditionally; the next request is accepted in IDLE.
- Latency: ready is low for WAIT_CYCLES+1 cycles per access; back-to-back accesses therefore take WAIT_CYCLES+2 cycles each.
- Index: off = addr - BASE_ADDR (32-bit modular); idx = off[31:2].
- Error cases:
  - Out-of-range (idx >= DEPTH_WORDS): err=1, write dropped, o_data_rd=0.
  - Misaligned (off[1:0]!=0): err=1, write dropped, o_data_rd=0.
  - Both rd and wr asserted: err=1, no write, o_data_rd=0.
- Reads return the full aligned word; the mask is ignored for reads (sign/zero extension is done in the core).
- A write with mask 4'b0000 completes normally with no array change and err=0.
- o_data_rd and o_data_err hold their value from DONE until the next DONE.
- Reset (rst_n=0 sampled at an edge):
  - state=IDLE, counter=0, o_data_rd=0, o_data_err=0.
  - o_data_ready is forced to 0 while rst_n=0.
  - Reset mid-BUSY aborts the access; a pending write is NOT committed.
  - Array contents are not cleared by reset.
- Simultaneous reset and DONE entry: reset wins; no write.

Test Plan:
- WAIT_CYCLES=2; write addr 0x10, data 0xDEADBEEF, mask 4'hF, hold until ready; then read 0x10 -> ready low for exactly 3 cycles on each access, ready high 1 cycle in DONE, read returns 0xDEADBEEF, err=0.
- Byte mask: after writing 0x11223344 to 0x20, write 0xAABBCCDD with mask 4'b0101 -> subsequent read of 0x20 returns 0x11BB33DD.
- WAIT_CYCLES=0 back-to-back: read 0x0, read 0x4, write 0x8 with enables held continuously -> each access has ready low 1 cycle then high 1 cycle; total 6 cycles; data correct.
- Errors: read 0x1002 (misaligned), write 4*DEPTH_WORDS with data 0x55, read with rd_en=wr_en=1 -> err=1 and o_data_rd=0 in each DONE; a follow-up read of word 0 is unchanged.
- Reset mid-BUSY: issue write 0xCAFEF00D to 0x30 over prior 0x12345678, assert rst_n=0 during the second BUSY cycle -> ready=0 during reset, outputs 0, state IDLE after release; read 0x30 returns 0x12345678.
- Request dropped during BUSY: assert wr_en for one cycle only (0x40, 0x0BADF00D) -> DONE still occurs after WAIT_CYCLES, and a read of 0x40 returns 0x0BADF00D.
